// File: rtl/pwm_fade_ctrl.sv
// Multi-channel PWM duty fader: each channel's current duty ramps one LSB per
// prescaler tick toward its programmed target, with optional immediate jumps.
module pwm_fade_ctrl #(
    parameter int N   = 4,
    parameter int M   = 4,
    parameter int CW  = 2,
    parameter int DIV = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_ch,
    input  logic [N-1:0]     wr_duty,
    input  logic             wr_imm,
    output logic [M*N-1:0]   w_out,
    output logic [M-1:0]     busy,
    output logic [M-1:0]     done
);

    localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [PW-1:0]         cnt_q, cnt_d;
    logic [M-1:0][N-1:0]   tgt_q, tgt_d;
    logic [M-1:0][N-1:0]   cur_q, cur_d;
    logic [M-1:0]          done_q, done_d;
    logic                  tick_s;
    logic                  wr_hit_s;

    assign tick_s   = (cnt_q == PW'(DIV - 1));
    // Out-of-range channel indices are dropped before they can touch any state.
    assign wr_hit_s = wr_en && ({{(32-CW){1'b0}}, wr_ch} < 32'(M));

    // Prescaler next state: free-running, independent of writes.
    always_comb begin
        cnt_d = cnt_q;
        if (tick_s) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + PW'(1);
        end
    end

    // Per-channel target load, ramp step against the pre-write target, done detect.
    always_comb begin
        tgt_d  = tgt_q;
        cur_d  = cur_q;
        done_d = '0;
        for (int k = 0; k < M; k++) begin
            if (wr_hit_s && ({{(32-CW){1'b0}}, wr_ch} == 32'(k))) begin
                tgt_d[k] = wr_duty;
            end else begin
                tgt_d[k] = tgt_q[k];
            end

            if (wr_hit_s && wr_imm && ({{(32-CW){1'b0}}, wr_ch} == 32'(k))) begin
                cur_d[k]  = wr_duty;
                done_d[k] = 1'b0;
            end else if (tick_s && (cur_q[k] < tgt_q[k])) begin
                cur_d[k]  = cur_q[k] + N'(1);
                done_d[k] = ((cur_q[k] + N'(1)) == tgt_d[k]);
            end else if (tick_s && (cur_q[k] > tgt_q[k])) begin
                cur_d[k]  = cur_q[k] - N'(1);
                done_d[k] = ((cur_q[k] - N'(1)) == tgt_d[k]);
            end else begin
                cur_d[k]  = cur_q[k];
                done_d[k] = 1'b0;
            end
        end
    end

    // State registers; reset abandons any ramp and restarts the prescaler.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q  <= '0;
            tgt_q  <= '0;
            cur_q  <= '0;
            done_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            tgt_q  <= tgt_d;
            cur_q  <= cur_d;
            done_q <= done_d;
        end
    end

    // Busy mirrors the registers directly so it drops alongside the done pulse.
    always_comb begin
        busy = '0;
        for (int k = 0; k < M; k++) begin
            busy[k] = (cur_q[k] != tgt_q[k]);
        end
    end

    assign w_out = cur_q;
    assign done  = done_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Self-checking bench for pwm_fade_ctrl: directed scenarios followed by random
// writes, all compared each cycle against an arithmetic reference model.
module tb_pwm_fade_ctrl;

    localparam int N   = 4;
    localparam int M   = 4;
    localparam int CW  = 3;
    localparam int DIV = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            wr_en;
    logic [CW-1:0]   wr_ch;
    logic [N-1:0]    wr_duty;
    logic            wr_imm;
    logic [M*N-1:0]  w_out;
    logic [M-1:0]    busy;
    logic [M-1:0]    done;

    int checks = 0;
    int errors = 0;

    int m_cur [M];
    int m_tgt [M];
    int m_done[M];
    int m_cnt;

    pwm_fade_ctrl #(.N(N), .M(M), .CW(CW), .DIV(DIV)) dut (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_duty (wr_duty),
        .wr_imm  (wr_imm),
        .w_out   (w_out),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < M; k++) begin
            m_cur[k]  = 0;
            m_tgt[k]  = 0;
            m_done[k] = 0;
        end
        m_cnt = 0;
    endtask

    task automatic compare_all(input string tag);
        logic [M*N-1:0] e_out;
        logic [M-1:0]   e_busy;
        logic [M-1:0]   e_done;
        for (int k = 0; k < M; k++) begin
            e_out[k*N +: N] = N'(m_cur[k]);
            e_busy[k]       = (m_cur[k] != m_tgt[k]);
            e_done[k]       = (m_done[k] != 0);
        end
        chk({tag, "_wout"}, 32'(w_out), 32'(e_out));
        chk({tag, "_busy"}, 32'(busy), 32'(e_busy));
        chk({tag, "_done"}, 32'(done), 32'(e_done));
    endtask

    // One clock: predict from spec rules, clock the DUT, compare, drop the write strobe.
    task automatic cycle(input string tag);
        int  n_cur[M];
        int  n_tgt[M];
        int  n_done[M];
        bit  tick;
        tick = (m_cnt == DIV - 1);
        for (int k = 0; k < M; k++) begin
            bit hit;
            hit       = wr_en && (int'(wr_ch) == k);
            n_tgt[k]  = hit ? int'(wr_duty) : m_tgt[k];
            n_cur[k]  = m_cur[k];
            n_done[k] = 0;
            if (hit && wr_imm) begin
                n_cur[k] = int'(wr_duty);
            end else if (tick && m_cur[k] != m_tgt[k]) begin
                n_cur[k]  = m_cur[k] + ((m_cur[k] < m_tgt[k]) ? 1 : -1);
                n_done[k] = (n_cur[k] == n_tgt[k]) ? 1 : 0;
            end
        end
        @(posedge clk);
        #1;
        m_cnt = tick ? 0 : m_cnt + 1;
        for (int k = 0; k < M; k++) begin
            m_cur[k]  = n_cur[k];
            m_tgt[k]  = n_tgt[k];
            m_done[k] = n_done[k];
        end
        compare_all(tag);
        wr_en   = 1'b0;
        wr_imm  = 1'b0;
    endtask

    task automatic write(input int ch, input int duty, input bit imm, input string tag);
        wr_en   = 1'b1;
        wr_ch   = CW'(ch);
        wr_duty = N'(duty);
        wr_imm  = imm;
        cycle(tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cycle(tag);
    endtask

    initial begin
        int  done0_cnt;
        bit  found;
        logic [M*N-1:0] snap;

        reset = 1'b1; wr_en = 1'b0; wr_ch = '0; wr_duty = '0; wr_imm = 1'b0;
        model_clear();
        #3;
        chk("reset_wout", 32'(w_out), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // Ramp up ch0 0->3, counting done pulses.
        write(0, 3, 1'b0, "up_wr");
        chk("up_busy0", 32'(busy[0]), 32'd1);
        done0_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            cycle("up");
            if (done[0]) done0_cnt++;
        end
        chk("up_final", 32'(w_out[3:0]), 32'd3);
        chk("up_done_pulses", 32'(done0_cnt), 32'd1);

        // Ramp down ch1 5->2.
        write(1, 5, 1'b1, "dn_imm");
        write(1, 2, 1'b0, "dn_wr");
        idle(16, "dn");
        chk("dn_final", 32'(w_out[7:4]), 32'd2);

        // Immediate jump on ch2.
        write(2, 15, 1'b1, "imm");
        chk("imm_val", 32'(w_out[11:8]), 32'd15);
        chk("imm_busy", 32'(busy[2]), 32'd0);
        chk("imm_done", 32'(done[2]), 32'd0);
        idle(6, "imm_hold");

        // Redirect ch0 on the very tick where it sits at 4 heading to 10.
        write(0, 0, 1'b1, "rd_zero");
        write(0, 10, 1'b0, "rd_wr");
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_cur[0] == 4 && m_cnt == DIV - 1) begin
                found = 1'b1;
                break;
            end
            cycle("rd_ramp");
        end
        chk("rd_sync", 32'(found), 32'd1);
        write(0, 2, 1'b0, "rd_redirect");
        chk("rd_step5", 32'(w_out[3:0]), 32'd5);
        idle(24, "rd_back");
        chk("rd_final", 32'(w_out[3:0]), 32'd2);

        // Out-of-range channel: nothing may move.
        snap = w_out;
        write(5, 9, 1'b1, "oor_imm");
        write(7, 1, 1'b0, "oor");
        chk("oor_wout", 32'(w_out), 32'(snap));

        // Reset in the middle of a ramp on ch3.
        write(3, 0, 1'b1, "rst_zero");
        write(3, 15, 1'b0, "rst_wr");
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (m_cur[3] == 6) begin
                found = 1'b1;
                break;
            end
            cycle("rst_ramp");
        end
        chk("rst_sync", 32'(found), 32'd1);
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        chk("rst_async_wout", 32'(w_out), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        @(posedge clk); #1;
        compare_all("rst_hold");
        reset = 1'b0;
        write(0, 9, 1'b0, "post_rst_wr");
        for (int i = 1; i < DIV - 1; i++) begin
            cycle("post_rst_wait");
        end
        chk("post_rst_no_step", 32'(w_out[3:0]), 32'd0);
        cycle("post_rst_tick");
        chk("post_rst_first", 32'(w_out[3:0]), 32'd1);

        // Random traffic, including out-of-range channels and immediate loads.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                wr_en   = 1'b1;
                wr_ch   = CW'($urandom_range(0, 7));
                wr_duty = N'($urandom_range(0, 15));
                wr_imm  = ($urandom_range(0, 3) == 0);
            end
            cycle("rand");
        end
        idle(80, "drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
